tank_input_sampler: RTL and testbench
=====================================

# tank_input_sampler

Player-input front end for one tank. It synchronizes and debounces four raw active-low direction buttons and one fire button, then priority-encodes the direction. Once per game frame, while the game is in play, it presents the result to the tank movement block as a `direction_in` / `valid_take_direction` pair, with a single-frame fire request alongside for the bullet logic.

## Interface
Parameters:
- FRAME_DIV, 833333: clk cycles per game frame (60 Hz at 50 MHz); must be ≥ 2.
- DEB_CYCLES, 250000: consecutive cycles a key must differ from its debounced state before that state flips; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_up_n, key_down_n, key_left_n, key_right_n  in  1 each  raw buttons, asynchronous, 0 = pressed.
- key_fire_n  in  1  raw fire button, asynchronous, 0 = pressed.
- game_state  in  2  2'b01 = play, 2'b10 = restart, other = idle.
- direction_in  out  3  0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 STAND; held between pulses.
- valid_take_direction  out  1  one-cycle pulse per frame, only in play.
- fire_req  out  1  one-cycle pulse, coincident with valid_take_direction.

## Operation
- **Synchronizer:** two flops per key. Their reset value is 1 (released).
- **Debounce:** one counter per key, width clog2(DEB_CYCLES+1).
  - If the synchronized value equals the stable value, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES-1 and the value still differs, the stable value takes the synchronized value on the next edge and the counter clears.
- **Priority encode** of the stable pressed keys: UP > DOWN > LEFT > RIGHT. No key pressed gives 4 (STAND). Opposite keys held together resolve by this priority (UP+DOWN gives 0).
- **Frame counter:** counts 0..FRAME_DIV-1 and wraps. The terminal count is the frame tick. In restart (2'b10) the counter is forced to 0.
- **At each frame tick with game_state == 2'b01:**
  - valid_take_direction is 1 for the next cycle.
  - direction_in is loaded with the encoded value.
  - fire_req equals fire_pend for the same cycle, and fire_pend clears.
- **At a frame tick in any other state:** no pulses are produced, and direction_in is loaded with 4.
- **Fire pending (fire_pend):**
  - Set by a released→pressed transition of the stable fire signal.
  - Further presses while it is set are ignored, so at most one fire per frame.
  - Cleared in restart.
  - If a press edge and a consuming tick occur in the same cycle, the tick consumes the old value and the new edge sets fire_pend again.

## Timing
- **Reset values:** direction_in = 4, valid_take_direction = 0, fire_req = 0. Internally, all stable keys released, fire_pend = 0, all counters 0.
- **Press to stable:** 2 synchronizer cycles + DEB_CYCLES cycles.
- **Stable to outputs:** sampled at the next frame tick; outputs are registered one cycle after the tick cycle.
- **Pulse spacing:** exactly FRAME_DIV cycles between consecutive valid pulses during uninterrupted play.
- **First pulse after leaving restart:** FRAME_DIV cycles after the last cycle of 2'b10.
- **Bounce:** a key glitch shorter than DEB_CYCLES produces no change in the stable value.
- **Reset mid-frame:** outputs and counters go to their reset values immediately; no partial pulse is produced.

## Configuration
- **TANK_INPUT_DEBOUNCE_EN defined:** the debounce counters are built as described above.
- **Not defined:**
  - The stable value equals the synchronizer output directly, with latency 2 cycles.
  - The counters are removed and DEB_CYCLES is ignored.
  - The fire edge is detected on the synchronized fire signal.

## Test plan
Bench parameters: FRAME_DIV=16, DEB_CYCLES=4, TANK_INPUT_DEBOUNCE_EN defined.
1. Reset, game_state=01, no keys → valid pulses every 16 cycles, direction_in=4, fire_req=0.
2. Hold key_left_n=0 → stable after 6 cycles; next pulse carries direction_in=2; a subsequent release returns 4.
3. key_up_n=0 for 3 cycles only (glitch) → direction_in stays 4, no change.
4. Hold key_up_n=0 and key_down_n=0 → direction_in=0; then release UP only → direction_in=1 at the following pulse.
5. Two fire presses within one frame → exactly one fire_req=1, coincident with valid; the next frame gives fire_req=0.
6. Switch game_state from 01 to 10 mid-frame for 5 cycles, then back to 01 → no pulses during 10 or within 15 cycles after; first pulse 16 cycles after 10 ends; pending fire discarded.

Source files
------------

// File: rtl/tank_input_sampler.sv
// tank_input_sampler: sync, debounce and priority-encode tank buttons, one sample per frame.
// Build option: define TANK_INPUT_DEBOUNCE_EN to include the per-key debounce counters.
module tank_input_sampler #(
    parameter int FRAME_DIV  = 833333,
    parameter int DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       key_left_n,
    input  logic       key_right_n,
    input  logic       key_fire_n,
    input  logic [1:0] game_state,
    output logic [2:0] direction_in,
    output logic       valid_take_direction,
    output logic       fire_req
);

    localparam logic [1:0] GS_PLAY    = 2'b01;
    localparam logic [1:0] GS_RESTART = 2'b10;

    localparam logic [2:0] DIR_UP    = 3'd0;
    localparam logic [2:0] DIR_DOWN  = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_RIGHT = 3'd3;
    localparam logic [2:0] DIR_STAND = 3'd4;

    localparam int FW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

    if (FRAME_DIV < 2 || DEB_CYCLES < 1) begin : g_bad_param
        $error("tank_input_sampler: FRAME_DIV must be >= 2, DEB_CYCLES >= 1");
    end

    // Key order: 0 up, 1 down, 2 left, 3 right, 4 fire (all active-low).
    logic [4:0] raw_n;
    logic [4:0] sync1_q;
    logic [4:0] sync2_q;
    logic [4:0] stable_n;

    assign raw_n = {key_fire_n, key_right_n, key_left_n, key_down_n, key_up_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
        end
    end

`ifdef TANK_INPUT_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [4:0]         stable_q;
    logic [4:0]         stable_d;
    logic [4:0][CW-1:0] cnt_q;
    logic [4:0][CW-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '1;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_n = stable_q;
`else
    assign stable_n = sync2_q;
`endif

    logic       fire_prev_q;
    logic       fire_edge;
    logic [3:0] pressed;
    logic [2:0] dir_enc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_prev_q <= 1'b1;
        end else begin
            fire_prev_q <= stable_n[4];
        end
    end

    assign fire_edge = fire_prev_q & ~stable_n[4];
    assign pressed   = ~stable_n[3:0];

    always_comb begin
        if (pressed[0]) begin
            dir_enc = DIR_UP;
        end else if (pressed[1]) begin
            dir_enc = DIR_DOWN;
        end else if (pressed[2]) begin
            dir_enc = DIR_LEFT;
        end else if (pressed[3]) begin
            dir_enc = DIR_RIGHT;
        end else begin
            dir_enc = DIR_STAND;
        end
    end

    logic [FW-1:0] frame_cnt_q;
    logic [FW-1:0] frame_cnt_d;
    logic          tick;
    logic          play;
    logic          restart;

    assign tick    = (frame_cnt_q == FW'(FRAME_DIV - 1));
    assign play    = (game_state == GS_PLAY);
    assign restart = (game_state == GS_RESTART);

    always_comb begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (restart || tick) begin
            frame_cnt_d = '0;
        end
    end

    logic [2:0] dir_q;
    logic [2:0] dir_d;
    logic       valid_q;
    logic       valid_d;
    logic       fire_q;
    logic       fire_d;
    logic       fire_pend_q;
    logic       fire_pend_d;

    // A consuming tick takes the old pending bit; a same-cycle edge re-arms it.
    always_comb begin
        valid_d     = 1'b0;
        fire_d      = 1'b0;
        dir_d       = dir_q;
        fire_pend_d = fire_pend_q | fire_edge;
        if (tick) begin
            if (play) begin
                valid_d     = 1'b1;
                fire_d      = fire_pend_q;
                dir_d       = dir_enc;
                fire_pend_d = fire_edge;
            end else begin
                dir_d = DIR_STAND;
            end
        end
        if (restart) begin
            fire_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            dir_q       <= DIR_STAND;
            valid_q     <= 1'b0;
            fire_q      <= 1'b0;
            fire_pend_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            dir_q       <= dir_d;
            valid_q     <= valid_d;
            fire_q      <= fire_d;
            fire_pend_q <= fire_pend_d;
        end
    end

    assign direction_in         = dir_q;
    assign valid_take_direction = valid_q;
    assign fire_req             = fire_q;

endmodule

// File: tb/tb_tank_input_sampler.sv
// tb_tank_input_sampler: directed stimulus with a queue of expected frame samples,
// checked by an independent monitor on the falling clock edge.
module tb_tank_input_sampler;

    typedef struct {
        int cyc;
        int dir;
        int fire;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_down_n = 1'b1;
    logic       key_left_n = 1'b1;
    logic       key_right_n = 1'b1;
    logic       key_fire_n = 1'b1;
    logic [1:0] game_state = 2'b01;
    logic [2:0] direction_in;
    logic       valid_take_direction;
    logic       fire_req;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   held = 4;
    exp_t sb[$];
    exp_t e;

    tank_input_sampler #(
        .FRAME_DIV (16),
        .DEB_CYCLES(4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .key_up_n            (key_up_n),
        .key_down_n          (key_down_n),
        .key_left_n          (key_left_n),
        .key_right_n         (key_right_n),
        .key_fire_n          (key_fire_n),
        .game_state          (game_state),
        .direction_in        (direction_in),
        .valid_take_direction(valid_take_direction),
        .fire_req            (fire_req)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; pulse k of an epoch lands at cyc 16*k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int c, input int d, input int f);
        exp_t x;
        x.cyc  = c;
        x.dir  = d;
        x.fire = f;
        sb.push_back(x);
    endtask

    task automatic at(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check("wait_cycle", cyc, n);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                check("pulse_seen", 0, 1);
                void'(sb.pop_front());
            end
            if (valid_take_direction) begin
                if (sb.size() == 0) begin
                    check("pulse_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_dir", int'(direction_in), e.dir);
                    check("pulse_fire", int'(fire_req), e.fire);
                    held = e.dir;
                end
            end else begin
                check("dir_held", int'(direction_in), held);
                check("fire_idle", int'(fire_req), 0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dir", int'(direction_in), 4);
        check("rst_valid", int'(valid_take_direction), 0);
        check("rst_fire", int'(fire_req), 0);
        rst_n = 1'b1;

        expect_pulse(16, 4, 0);
        expect_pulse(32, 4, 0);
        at(33);
        key_left_n = 1'b0;
        expect_pulse(48, 2, 0);
        expect_pulse(64, 2, 0);
        at(65);
        key_left_n = 1'b1;
        expect_pulse(80, 4, 0);

        at(84);
        key_up_n = 1'b0;
        at(87);
        key_up_n = 1'b1;
        expect_pulse(96, 4, 0);

        at(97);
        key_up_n   = 1'b0;
        key_down_n = 1'b0;
        expect_pulse(112, 0, 0);
        at(113);
        key_up_n = 1'b1;
        expect_pulse(128, 1, 0);
        at(129);
        key_down_n = 1'b1;
        expect_pulse(144, 4, 0);

        at(141);
        key_fire_n = 1'b0;
        at(145);
        key_fire_n = 1'b1;
        at(149);
        key_fire_n = 1'b0;
        at(153);
        key_fire_n = 1'b1;
        expect_pulse(160, 4, 1);
        expect_pulse(176, 4, 0);

        at(177);
        key_fire_n = 1'b0;
        at(181);
        key_fire_n = 1'b1;
        at(185);
        game_state = 2'b10;
        at(190);
        game_state = 2'b01;
        expect_pulse(206, 4, 0);

        at(209);
        key_left_n = 1'b0;
        expect_pulse(222, 2, 0);

        at(228);
        rst_n      = 1'b0;
        key_left_n = 1'b1;
        held       = 4;
        #1;
        check("midrst_dir", int'(direction_in), 4);
        check("midrst_valid", int'(valid_take_direction), 0);
        check("midrst_fire", int'(fire_req), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_pulse(16, 4, 0);
        at(20);

        check("queue_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
